// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared cache constants, FSM encodings and geometry helper
//
// Purpose : default cache geometry, refill FSM state encodings and the tag-width
//           derivation shared by inst_cache and icache_array (and, later, the
//           data cache).
// Ports   : none (package).

package inst_cache_pkg;

  localparam int ICACHE_INDEX_W_DEF  = 6;
  localparam int ICACHE_OFFSET_W_DEF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_REFILL = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  // Tag covers every address bit above index, word offset and byte offset.
  function automatic int tag_width(input int index_w, input int offset_w);
    return 32 - index_w - offset_w - 2;
  endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage for the direct-mapped instruction cache
//
// Purpose : per-line valid bit, tag and data line. Asynchronous read of one
//           line, one synchronous write port, invalidate-all input.
// Ports   : clk, rst (sync, active-low: clears valid bits only)
//           inv                 - clear every valid bit at the next edge
//           rd_idx              - read index; rd_valid/rd_tag/rd_line combinational
//           we/wr_idx/wr_tag/wr_line - line write, sets valid unless inv is high

module icache_array
  import inst_cache_pkg::*;
#(
  parameter  int INDEX_W    = ICACHE_INDEX_W_DEF,
  parameter  int OFFSET_W   = ICACHE_OFFSET_W_DEF,
  localparam int TAG_W      = tag_width(INDEX_W, OFFSET_W),
  localparam int LINES      = 1 << INDEX_W,
  localparam int LINE_WORDS = 1 << OFFSET_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inv,
  input  logic [INDEX_W-1:0]           rd_idx,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_WORDS-1:0][31:0]  rd_line,
  input  logic                         we,
  input  logic [INDEX_W-1:0]           wr_idx,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [LINE_WORDS-1:0][31:0]  wr_line
);

  logic [LINES-1:0]            valid_q, valid_d;
  logic [TAG_W-1:0]            tag_q  [LINES];
  logic [LINE_WORDS-1:0][31:0] data_q [LINES];

  // Invalidate wins over a coincident write: the line lands but stays invalid.
  always_comb begin
    valid_d = valid_q;
    if (we) begin
      valid_d[wr_idx] = 1'b1;
    end
    if (inv) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are never cleared; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with line refill FSM
//
// Purpose : zero-latency hit path to the fetch stage; on a miss stalls fetch and
//           refills one line over a request/grant + beat-valid burst.
// Config  : ICACHE_STATS_EN - when defined, hit_cnt/miss_cnt are live counters;
//           otherwise both are tied to zero.
// Ports   : clk, rst (sync, active-low)
//           fetch_en, pcF -> instrF, icache_stall   (fetch side)
//           inv                                      (invalidate all lines)
//           mem_req, mem_addr, mem_gnt, mem_rvalid, mem_rdata (refill bus master)
//           hit_cnt, miss_cnt                        (statistics)

module inst_cache
  import inst_cache_pkg::*;
#(
  parameter  int INDEX_W    = ICACHE_INDEX_W_DEF,
  parameter  int OFFSET_W   = ICACHE_OFFSET_W_DEF,
  localparam int TAG_W      = tag_width(INDEX_W, OFFSET_W),
  localparam int LINE_WORDS = 1 << OFFSET_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        icache_stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  logic [1:0]                  state_q, state_d;
  logic [31:0]                 addr_q, addr_d;
  logic [OFFSET_W-1:0]         cnt_q, cnt_d;
  logic [LINE_WORDS-1:0][31:0] line_buf_q, line_buf_d;

  logic [INDEX_W-1:0]          pc_idx;
  logic [TAG_W-1:0]            pc_tag;
  logic [OFFSET_W-1:0]         pc_off;
  logic                        rd_valid;
  logic [TAG_W-1:0]            rd_tag;
  logic [LINE_WORDS-1:0][31:0] rd_line;
  logic                        hit;
  logic                        miss_start;
  logic                        unused_pc_bits;

  assign pc_idx         = pcF[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  assign pc_tag         = pcF[31:32-TAG_W];
  assign pc_off         = pcF[OFFSET_W+1:2];
  assign unused_pc_bits = ^pcF[1:0];

  icache_array #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .inv      (inv),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (state_q == ST_WRITE),
    .wr_idx   (addr_q[INDEX_W+OFFSET_W+1:OFFSET_W+2]),
    .wr_tag   (addr_q[31:32-TAG_W]),
    .wr_line  (line_buf_q)
  );

  assign hit          = rd_valid & (rd_tag == pc_tag);
  assign instrF       = hit ? rd_line[pc_off] : 32'h0;
  assign icache_stall = (state_q != ST_IDLE) | (fetch_en & ~hit);
  assign miss_start   = (state_q == ST_IDLE) & fetch_en & ~hit;
  assign mem_req      = (state_q == ST_REQ);
  assign mem_addr     = addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    line_buf_d = line_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_start) begin
          addr_d  = {pcF[31:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_rvalid) begin
          line_buf_d[cnt_q] = mem_rdata;
          cnt_d             = cnt_q + 1'b1;
          // Counter all-ones means this is the last word of the line.
          if (&cnt_q) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Line buffer contents only matter once a full burst has landed.
  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q  + {31'b0, (state_q == ST_IDLE) & fetch_en & hit};
    miss_cnt_d = miss_cnt_q + {31'b0, miss_start};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'h0;
  assign miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache

module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] pcF = 32'h0;
  logic        inv = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instrF;
  logic        icache_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .pcF          (pcF),
    .instrF       (instrF),
    .icache_stall (icache_stall),
    .inv          (inv),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    int          gw;        // REQ cycles before grant (0 = expect hit)
    int          stall;     // expected stalled cycles
    int          refs;      // expected refill requests
    int          inv_mode;  // 0 none, 1 inv in WRITE, 2 inv mid-REFILL
  } vec_t;

  vec_t tbl[20];

  // Backing memory: the 0x100 line holds the known beats, everything else a hash.
  function automatic logic [31:0] model(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h0000010) return 32'h11 * ({30'b0, w[3:2]} + 32'd1);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Fetch one address, acting as the memory slave, until the fetch completes.
  task automatic run_fetch(input logic [31:0] pc, input int gw, input int exp_stall,
                           input int exp_ref, input int inv_mode, input string nm);
    int          stalls = 0;
    int          reqs = 0;
    int          beat = 0;
    int          refills = 0;
    bit          granted = 0;
    bit          done = 0;
    bit          inv_done = 0;
    logic [31:0] line;
    line = {pc[31:4], 4'h0};
    fetch_en = 1'b1;
    pcF = pc;
    exp_q.push_back(model(pc));
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      inv = 1'b0;
      if (mem_req) begin
        if (reqs == 0) begin
          refills++;
          chk({nm, " mem_addr"}, mem_addr, line);
          granted = 0;
          beat = 0;
        end
        reqs++;
        if (reqs >= gw) begin
          mem_gnt = 1'b1;
          granted = 1;
          reqs = 0;
        end
      end else if (granted && beat < 4) begin
        mem_rvalid = 1'b1;
        mem_rdata = model(line + 32'(4 * beat));
        beat++;
        if (inv_mode == 2 && beat == 2 && !inv_done) begin
          inv = 1'b1;
          inv_done = 1;
        end
      end else if (granted && beat == 4) begin
        if (inv_mode == 1 && !inv_done) begin
          inv = 1'b1;
          inv_done = 1;
        end
        granted = 0;
      end
      #1;
      if (icache_stall) begin
        stalls++;
      end else begin
        chk({nm, " instrF"}, instrF, exp_q.pop_front());
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: still stalled after 64 cycles, expected completion", nm);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    fetch_en = 1'b0;
    inv = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    chk({nm, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({nm, " refills"}, 32'(refills), 32'(exp_ref));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h0000_0100, 2,  8, 1, 0};
    tbl[1]  = '{32'h0000_0104, 0,  0, 0, 0};
    tbl[2]  = '{32'h0000_0108, 0,  0, 0, 0};
    tbl[3]  = '{32'h0000_010C, 0,  0, 0, 0};
    tbl[4]  = '{32'h0000_0500, 1,  7, 1, 0};
    tbl[5]  = '{32'h0000_0504, 0,  0, 0, 0};
    tbl[6]  = '{32'h0000_0100, 3,  9, 1, 0};
    tbl[7]  = '{32'h0000_050C, 1,  7, 1, 0};
    tbl[8]  = '{32'h0000_03F0, 1,  7, 1, 0};
    tbl[9]  = '{32'h0000_03FC, 0,  0, 0, 0};
    tbl[10] = '{32'h0000_0000, 1,  7, 1, 0};
    tbl[11] = '{32'hFFFF_FFF4, 2,  8, 1, 0};
    tbl[12] = '{32'h0000_03F4, 1,  7, 1, 0};
    tbl[13] = '{32'h0000_0000, 0,  0, 0, 0};
    tbl[14] = '{32'h0000_0200, 1, 14, 2, 1};
    tbl[15] = '{32'h0000_0204, 0,  0, 0, 0};
    tbl[16] = '{32'h0000_0000, 1,  7, 1, 0};
    tbl[17] = '{32'h0000_0600, 1,  7, 1, 2};
    tbl[18] = '{32'h0000_0608, 0,  0, 0, 0};
    tbl[19] = '{32'h0000_0004, 1,  7, 1, 0};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst stall", {31'b0, icache_stall}, 32'h0);
    chk("rst hit_cnt", hit_cnt, 32'h0);
    chk("rst miss_cnt", miss_cnt, 32'h0);
    fetch_en = 1'b1;
    pcF = 32'h100;
    #1;
    chk("rst lookup stall", {31'b0, icache_stall}, 32'h1);
    chk("rst lookup instrF", instrF, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    fetch_en = 1'b0;
    pcF = 32'h300;

    // fetch_en low in IDLE: no lookup, no miss.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle stall", {31'b0, icache_stall}, 32'h0);
      chk("idle mem_req", {31'b0, mem_req}, 32'h0);
      @(negedge clk);
    end

    for (int i = 0; i < 20; i++) begin
      run_fetch(tbl[i].pc, tbl[i].gw, tbl[i].stall, tbl[i].refs, tbl[i].inv_mode,
                $sformatf("row%0d", i));
      if (i == 2) begin
`ifdef ICACHE_STATS_EN
        chk("stats miss_cnt", miss_cnt, 32'd1);
        chk("stats hit_cnt", hit_cnt, 32'd3);
`else
        chk("stats miss_cnt", miss_cnt, 32'd0);
        chk("stats hit_cnt", hit_cnt, 32'd0);
`endif
      end
    end

    // Reset in the middle of a refill, then stray beats.
    fetch_en = 1'b1;
    pcF = 32'h900;
    #1;
    chk("midrst miss stall", {31'b0, icache_stall}, 32'h1);
    @(negedge clk);
    #1;
    chk("midrst mem_req", {31'b0, mem_req}, 32'h1);
    chk("midrst mem_addr", mem_addr, 32'h900);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fetch_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_0000 + 32'(i);
      #1;
      chk("stray mem_req", {31'b0, mem_req}, 32'h0);
      chk("stray stall", {31'b0, icache_stall}, 32'h0);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    chk("midrst miss_cnt", miss_cnt, 32'h0);
    run_fetch(32'h100, 1, 7, 1, 0, "post_rst_0x100");
    run_fetch(32'h604, 1, 7, 1, 0, "post_rst_0x604");
    run_fetch(32'h10C, 0, 0, 0, 0, "post_rst_hit");

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
